// File: rtl/led_drv_pkg.sv
// led_drv_pkg: types and constants shared by the LED matrix serial link transmitter and driver.
package led_drv_pkg;
  localparam int LED_NLEDS  = 64;
  localparam int DIN_BIT    = 0;
  localparam int DCLK_BIT   = 1;
  localparam int STROBE_BIT = 2;
  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, SETTLE, STROBE} ser_state_t;
endpackage

// File: rtl/led_phase_timer.sv
// led_phase_timer: loadable 8-bit down-counter; expire marks the last cycle of a loaded phase.
module led_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       expire
);
  logic [7:0] cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= load ? load_val : cnt_q - {7'd0, |cnt_q};
  assign expire = cnt_q == 8'd1;
endmodule

// File: rtl/led_frame_serializer.sv
// led_frame_serializer: shifts a frame MSB first over din/dclk, then pulses strobe.
// Define LED_SER_AUTO_REPEAT_EN to retransmit the last accepted frame whenever idle.
module led_frame_serializer
  import led_drv_pkg::*;
#(
  parameter int NLEDS      = LED_NLEDS,
  parameter int DIV        = 4,
  parameter int STB_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NLEDS-1:0] frame,
  input  logic             frame_valid,
  output logic             frame_ready,
  output logic             din,
  output logic             dclk,
  output logic             strobe,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(NLEDS + 1);
  ser_state_t       state_q;
  logic [NLEDS-1:0] sreg_q, sreg_sh, start_frame;
  logic [BW-1:0]    bits_q;
  logic             din_q, dclk_q, strobe_q, busy_q, done_q, ready_q;
  logic             start, load, expire;
  logic [7:0]       load_val;
`ifdef LED_SER_AUTO_REPEAT_EN
  logic [NLEDS-1:0] held_q;
  logic             held_vld_q;
  assign start       = frame_valid | held_vld_q;
  assign start_frame = frame_valid ? frame : held_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      held_q     <= '0;
      held_vld_q <= 1'b0;
    end else if (state_q == IDLE && frame_valid) begin
      held_q     <= frame;
      held_vld_q <= 1'b1;
    end
`else
  assign start       = frame_valid;
  assign start_frame = frame;
`endif
  assign sreg_sh  = sreg_q << 1;
  // Leaving STROBE returns to IDLE, so the timer is left to run down instead of reloading.
  assign load     = state_q == IDLE ? start : expire && state_q != STROBE;
  assign load_val = state_q == SETTLE ? 8'(STB_CYCLES) : 8'(DIV);
  led_phase_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .load_val(load_val),
    .expire  (expire)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      bits_q   <= '0;
      din_q    <= 1'b0;
      dclk_q   <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= SHIFT_LO;
          sreg_q  <= start_frame;
          bits_q  <= BW'(NLEDS);
          din_q   <= start_frame[NLEDS-1];
          busy_q  <= 1'b1;
          ready_q <= 1'b0;
        end
        SHIFT_LO: if (expire) begin
          state_q <= SHIFT_HI;
          dclk_q  <= 1'b1;
        end
        SHIFT_HI: if (expire) begin
          sreg_q  <= sreg_sh;
          bits_q  <= bits_q - BW'(1);
          dclk_q  <= 1'b0;
          state_q <= bits_q == BW'(1) ? SETTLE : SHIFT_LO;
          din_q   <= bits_q == BW'(1) ? 1'b0 : sreg_sh[NLEDS-1];
        end
        SETTLE: if (expire) begin
          state_q  <= STROBE;
          strobe_q <= 1'b1;
        end
        STROBE: if (expire) begin
          state_q  <= IDLE;
          strobe_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          ready_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign frame_ready = ready_q;
  assign din         = din_q;
  assign dclk        = dclk_q;
  assign strobe      = strobe_q;
  assign busy        = busy_q;
  assign done        = done_q;
endmodule

// File: tb/tb_led_frame_serializer.sv
// tb_led_frame_serializer: directed checks of the serializer against a model of the driver's shift chain.
module tb_led_frame_serializer;
  logic        clk = 1'b0, reset = 1'b1;
  logic [63:0] frame = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready, din, dclk, strobe, busy, done;
  logic [7:0]  frame2 = '0;
  logic        valid2 = 1'b0;
  logic        ready2, din2, dclk2, strobe2, busy2, done2;
  int          compared = 0, mismatched = 0;
  logic [63:0] chain = '0, latched = '0;
  logic [7:0]  chain2 = '0, latched2 = '0;
  int          rises = 0, pulses = 0, rises2 = 0;
  int          cyc = 0, fall_cyc = 0, rise_cyc = 0, stb_hi = 0;
  logic        pd = 1'b0, ps = 1'b0;
  int          n, r0, p0, h0;
  logic        sb;
  always #5 clk = ~clk;
  led_frame_serializer #(.NLEDS(64), .DIV(2), .STB_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .frame(frame), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .din(din), .dclk(dclk), .strobe(strobe), .busy(busy), .done(done)
  );
  led_frame_serializer #(.NLEDS(8), .DIV(1), .STB_CYCLES(1)) dut2 (
    .clk(clk), .reset(reset), .frame(frame2), .frame_valid(valid2), .frame_ready(ready2),
    .din(din2), .dclk(dclk2), .strobe(strobe2), .busy(busy2), .done(done2)
  );
  // Driver model: shift toward higher indices on dclk rise, latch on strobe rise.
  always @(posedge dclk) begin
    chain <= {chain[62:0], din};
    rises <= rises + 1;
  end
  always @(posedge strobe) begin
    latched <= chain;
    pulses  <= pulses + 1;
  end
  always @(posedge dclk2) begin
    chain2 <= {chain2[6:0], din2};
    rises2 <= rises2 + 1;
  end
  always @(posedge strobe2) latched2 <= chain2;
  always @(posedge clk) begin
    if (pd && !dclk) fall_cyc = cyc;
    if (!ps && strobe) rise_cyc = cyc;
    if (strobe) stb_hi = stb_hi + 1;
    pd  = dclk;
    ps  = strobe;
    cyc = cyc + 1;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [63:0] f, input string tag);
    @(negedge clk);
    frame = f;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    chk(tag, busy, 1);
  endtask
  task automatic run_to_done(input bit sel, output int cnt, output logic stb_before);
    logic d;
    cnt = 0;
    d = 1'b0;
    stb_before = 1'b0;
    while (!d && cnt < 3000) begin
      stb_before = sel ? strobe2 : strobe;
      @(negedge clk);
      cnt++;
      d = sel ? done2 : done;
    end
    chk("done_seen", d, 1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_din", din, 0);
    chk("rst_dclk", dclk, 0);
    chk("rst_strobe", strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", frame_ready, 1);
    // Single frame with only the end bits set
    r0 = rises; p0 = pulses; h0 = stb_hi;
    send(64'h8000_0000_0000_0001, "t1_busy");
    chk("t1_ready_low", frame_ready, 0);
    run_to_done(0, n, sb);
    chk("t1_len", n, 261);
    chk("t1_rises", rises - r0, 64);
    chk("t1_latch", latched, 64'h8000_0000_0000_0001);
    chk("t1_pulses", pulses - p0, 1);
    chk("t1_stb_width", stb_hi - h0, 3);
    chk("t1_stb_delay", rise_cyc - fall_cyc, 2);
    chk("t1_ready_back", frame_ready, 1);
    // Held-valid frame, next frame offered in the done cycle
    frame = 64'hA5A5_A5A5_A5A5_A5A5;
    frame_valid = 1'b1;
    @(negedge clk);
    chk("t2_busy", busy, 1);
    run_to_done(0, n, sb);
    chk("t2_len", n, 261);
    chk("t2_latch", latched, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("t3_stb_before_done", sb, 1);
    chk("t3_stb_at_done", strobe, 0);
    frame = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk("t3_back_to_back", busy, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      frame_valid = i[0];
      frame = '0;
    end
    frame_valid = 1'b0;
    run_to_done(0, n, sb);
    chk("t3_len", n + 20, 261);
    chk("t3_latch", latched, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (10) @(negedge clk);
`ifdef LED_SER_AUTO_REPEAT_EN
    chk("t3_repeat_busy", busy, 1);
`else
    chk("t3_idle_busy", busy, 0);
    chk("t3_idle_ready", frame_ready, 1);
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    // Reset during bit 30
    r0 = rises; p0 = pulses;
    send(64'h0123_4567_89AB_CDEF, "t4_busy");
    for (int k = 0; k < 1000 && rises - r0 < 30; k++) @(negedge clk);
    chk("t4_reach_bit30", rises - r0, 30);
    reset = 1'b1;
    #1;
    chk("t4_rst_din", din, 0);
    chk("t4_rst_dclk", dclk, 0);
    chk("t4_rst_strobe", strobe, 0);
    chk("t4_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    chk("t4_no_strobe", pulses - p0, 0);
    chk("t4_display_kept", latched, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t4_ready", frame_ready, 1);
    send(64'h0123_4567_89AB_CDEF, "t4_resend_busy");
    run_to_done(0, n, sb);
    chk("t4_len", n, 261);
    chk("t4_latch", latched, 64'h0123_4567_89AB_CDEF);
    // Narrow instance: DIV=1, STB_CYCLES=1, NLEDS=8
    r0 = rises2;
    @(negedge clk);
    frame2 = 8'hB2;
    valid2 = 1'b1;
    @(negedge clk);
    valid2 = 1'b0;
    chk("t6_busy", busy2, 1);
    run_to_done(1, n, sb);
    chk("t6_len", n, 18);
    chk("t6_rises", rises2 - r0, 8);
    chk("t6_latch", latched2, 8'hB2);
`ifdef LED_SER_AUTO_REPEAT_EN
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    p0 = pulses;
    send(64'h1234_5678_9ABC_DEF0, "t5_busy");
    run_to_done(0, n, sb);
    chk("t5_len", n, 261);
    chk("t5_latch", latched, 64'h1234_5678_9ABC_DEF0);
    run_to_done(0, n, sb);
    chk("t5_repeat_period", n, 262);
    chk("t5_repeat_pulses", pulses - p0, 2);
    repeat (10) @(negedge clk);
    frame = '0;
    frame_valid = 1'b1;
    run_to_done(0, n, sb);
    chk("t5_repeat2_period", n + 10, 262);
    chk("t5_latch_repeat", latched, 64'h1234_5678_9ABC_DEF0);
    @(negedge clk);
    frame_valid = 1'b0;
    chk("t5_new_busy", busy, 1);
    run_to_done(0, n, sb);
    chk("t5_new_len", n, 261);
    chk("t5_new_latch", latched, 64'h0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
